// File: rtl/v_rams_arb2.sv
// Round-robin arbiter sharing one single-port read-first RAM between two requesters.
// Define ARB_CLEAR_EN to zero-fill the RAM with a clear sweep after every reset.
module v_rams_arb2 #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] din0,
    output logic          gnt0,
    output logic          rvld0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] din1,
    output logic          gnt1,
    output logic          rvld1,
    output logic [DW-1:0] rdata1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    logic          last_gnt_q, last_gnt_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          rd_q, rd_d;
    logic          tag_q, tag_d;
    logic          rvld_q, rvld_d;
    logic          rtag_q, rtag_d;
    logic          serve;

`ifdef ARB_CLEAR_EN
    typedef enum logic {CLEAR, SERVE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // One zero write per cycle; leave CLEAR after the top address has been issued.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) begin
                state_d = SERVE;
            end
        end
    end

    assign serve = (state_q == SERVE);
    assign busy  = (state_q == CLEAR);
`else
    assign serve = 1'b1;
    assign busy  = 1'b0;
`endif

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        last_gnt_d = last_gnt_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rd_d       = 1'b0;
        tag_d      = tag_q;
        rvld_d     = rd_q;
        rtag_d     = tag_q;
`ifdef ARB_CLEAR_EN
        if (state_q == CLEAR) begin
            ram_we_d   = 1'b1;
            ram_addr_d = clr_addr_q;
            ram_din_d  = '0;
        end
`endif
        // Contention goes to the port that did not win last time.
        if (serve && req0 && (!req1 || last_gnt_q)) begin
            gnt0 = 1'b1;
        end else if (serve && req1) begin
            gnt1 = 1'b1;
        end
        if (gnt0) begin
            last_gnt_d = 1'b0;
            ram_we_d   = we0;
            ram_addr_d = addr0;
            ram_din_d  = din0;
            rd_d       = !we0;
            tag_d      = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
            ram_we_d   = we1;
            ram_addr_d = addr1;
            ram_din_d  = din1;
            rd_d       = !we1;
            tag_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rd_q       <= 1'b0;
            tag_q      <= 1'b0;
            rvld_q     <= 1'b0;
            rtag_q     <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rd_q       <= rd_d;
            tag_q      <= tag_d;
            rvld_q     <= rvld_d;
            rtag_q     <= rtag_d;
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign rvld0    = rvld_q && !rtag_q;
    assign rvld1    = rvld_q && rtag_q;
    assign rdata0   = ram_dout;
    assign rdata1   = ram_dout;

endmodule
